// File: rtl/msg_packer.sv
// msg_packer: packs DATA_W-bit stream words into MSG_BITS-wide messages held in an FWFT message FIFO.
// Define MSG_PACKER_CHECKSUM_EN to add m_csum_o, the XOR of all valid words of the head message.
`timescale 1ns/1ps
module msg_packer #(
  parameter int DATA_W     = 8,
  parameter int MSG_BITS   = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 1,
  localparam int WORDS     = MSG_BITS / DATA_W,
  localparam int LEN_W     = $clog2(WORDS) + 1,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [DATA_W-1:0]   s_data_i,
  input  logic                s_valid_i,
  input  logic                s_last_i,
  output logic                s_ready_o,
  output logic [MSG_BITS-1:0] m_msg_o,
  output logic [LEN_W-1:0]    m_len_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [CNT_W-1:0]    m_count_o
`ifdef MSG_PACKER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]   m_csum_o
`endif
);

  localparam int IDX_W = $clog2(WORDS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    cur_idx;
  logic [MSG_BITS-1:0] asm_q, asm_d;
  logic [MSG_BITS-1:0] asm_word;

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [MSG_BITS-1:0] msg_mem_q [FIFO_DEPTH];
  logic [LEN_W-1:0]    len_mem_q [FIFO_DEPTH];

  logic                full;
  logic                empty;
  logic                accept;
  logic                last_word;
  logic                push;
  logic                pop;
  logic [LEN_W-1:0]    push_len;

  // Flow control looks only at the registered count, so a full FIFO stalls
  // the input even if the consumer is popping in the same cycle.
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign s_ready_o = !full;
  assign accept    = s_valid_i & s_ready_o;
  assign pop       = !empty & m_ready_i;

  assign cur_idx   = (state_q == ST_FILL) ? idx_q : '0;
  assign last_word = s_last_i | (cur_idx == IDX_W'(WORDS - 1));
  assign push      = accept & last_word;
  assign push_len  = LEN_W'(cur_idx) + LEN_W'(1);

  always_comb begin
    asm_word = asm_q;
    for (int k = 0; k < WORDS; k++) begin
      if (cur_idx == IDX_W'(k)) begin
        if (MSB_FIRST != 0) begin
          asm_word[MSG_BITS-1-k*DATA_W -: DATA_W] = s_data_i;
        end else begin
          asm_word[k*DATA_W +: DATA_W] = s_data_i;
        end
      end
    end
  end

  // A completing word leaves the assembly register zeroed so that the slots
  // of the next (possibly short) message start out empty.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    if (accept) begin
      if (last_word) begin
        state_d = ST_IDLE;
        idx_d   = '0;
        asm_d   = '0;
      end else begin
        state_d = ST_FILL;
        idx_d   = cur_idx + IDX_W'(1);
        asm_d   = asm_word;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      msg_mem_q[wr_ptr_q] <= asm_word;
      len_mem_q[wr_ptr_q] <= push_len;
    end
  end

  assign m_valid_o = !empty;
  assign m_count_o = count_q;
  assign m_msg_o   = empty ? '0 : msg_mem_q[rd_ptr_q];
  assign m_len_o   = empty ? '0 : len_mem_q[rd_ptr_q];

`ifdef MSG_PACKER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
  logic [DATA_W-1:0] csum_word;
  logic [DATA_W-1:0] csum_mem_q [FIFO_DEPTH];

  assign csum_word = csum_q ^ s_data_i;

  always_comb begin
    csum_d = csum_q;
    if (accept) begin
      csum_d = last_word ? '0 : csum_word;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      csum_mem_q[wr_ptr_q] <= csum_word;
    end
  end

  assign m_csum_o = empty ? '0 : csum_mem_q[rd_ptr_q];
`endif

endmodule
